// File: rtl/csd_to_bin_serial_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// csd_to_bin_serial_if
// Handshake bundle for the serial CSD-to-binary decoder.
//   Input channel  : in_valid, in_ready, in_mag[N-1:0], in_sign[N-1:0]
//   Output channel : out_valid, out_ready, out_data[W-1:0], out_err
// The slave modport is the decoder side; the master modport is the side
// that supplies CSD words and consumes decoded results.
// ---------------------------------------------------------------------------
interface csd_to_bin_serial_if #(
    parameter int N = 9,
    parameter int W = N + 1
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_mag;
    logic [N-1:0] in_sign;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_err;

    modport slave (
        input  in_valid,
        input  in_mag,
        input  in_sign,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_err
    );

    modport master (
        output in_valid,
        output in_mag,
        output in_sign,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_err
    );
endinterface

// File: rtl/csd_to_bin_serial.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// csd_to_bin_serial
// Serial decoder from canonical-signed-digit words to two's complement.
// One digit is consumed per clock, MSB first, with Horner accumulation
// (acc = 2*acc + d). Words violating CSD non-adjacency are flagged on
// out_err but still decoded arithmetically.
// Ports:
//   clk   : sole clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of csd_to_bin_serial_if (input and output handshakes)
// ---------------------------------------------------------------------------
module csd_to_bin_serial #(
    parameter int N = 9,
    parameter int W = N + 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    csd_to_bin_serial_if.slave    bus
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

    stateT         state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  acc_q, acc_d;
    logic [N-1:0]  mag_q, mag_d;
    logic [N-1:0]  sign_q, sign_d;
    logic          prevMag_q, prevMag_d;
    logic          err_q, err_d;
    logic [W-1:0]  outData_q, outData_d;
    logic          outErr_q, outErr_d;

    logic          inReady;
    logic          outValid;
    logic          accept;
    logic [W-1:0]  digitVal;
    logic [W-1:0]  accStep;
    logic          errStep;

    // The digit under consideration always sits in the MSB of the shift
    // registers. prevMag_q remembers the magnitude of the digit consumed on
    // the previous edge, which is the neighbour one position higher; it is
    // cleared on load so the top digit has no pair term.
    assign digitVal = mag_q[N-1] ? (sign_q[N-1] ? {W{1'b1}} : W'(1)) : '0;
    assign accStep  = (acc_q << 1) + digitVal;
    assign errStep  = err_q | (mag_q[N-1] & prevMag_q);
    assign accept   = bus.in_valid & inReady;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. From DONE a completed output handshake either
    // returns to IDLE or, if a new word is waiting, jumps straight to RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept) state_d = RUN;
            RUN:  if (cnt_q == '0) state_d = DONE;
            DONE: if (bus.out_ready) state_d = bus.in_valid ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs. in_ready is forced low while reset is held, and in
    // DONE follows out_ready so a new word can enter as the result leaves.
    always_comb begin
        inReady  = 1'b0;
        outValid = 1'b0;
        case (state_q)
            IDLE: inReady = 1'b1;
            DONE: begin
                inReady  = bus.out_ready;
                outValid = 1'b1;
            end
            default: ;
        endcase
        if (!rst_n) inReady = 1'b0;
    end

    // Datapath next values: load the word on accept, otherwise shift one
    // digit per RUN cycle and capture the final result on the last digit.
    always_comb begin
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mag_d     = mag_q;
        sign_d    = sign_q;
        prevMag_d = prevMag_q;
        err_d     = err_q;
        outData_d = outData_q;
        outErr_d  = outErr_q;
        if (accept) begin
            mag_d     = bus.in_mag;
            sign_d    = bus.in_sign;
            acc_d     = '0;
            cnt_d     = CW'(N - 1);
            err_d     = 1'b0;
            prevMag_d = 1'b0;
        end else if (state_q == RUN) begin
            acc_d     = accStep;
            err_d     = errStep;
            prevMag_d = mag_q[N-1];
            mag_d     = mag_q << 1;
            sign_d    = sign_q << 1;
            cnt_d     = cnt_q - CW'(1);
            if (cnt_q == '0) begin
                outData_d = accStep;
                outErr_d  = errStep;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            mag_q     <= '0;
            sign_q    <= '0;
            prevMag_q <= 1'b0;
            err_q     <= 1'b0;
            outData_q <= '0;
            outErr_q  <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mag_q     <= mag_d;
            sign_q    <= sign_d;
            prevMag_q <= prevMag_d;
            err_q     <= err_d;
            outData_q <= outData_d;
            outErr_q  <= outErr_d;
        end
    end

    assign bus.in_ready  = inReady;
    assign bus.out_valid = outValid;
    assign bus.out_data  = outData_q;
    assign bus.out_err   = outErr_q;

endmodule

// File: tb/tb_csd_to_bin_serial.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_csd_to_bin_serial
// Self-checking bench for csd_to_bin_serial. Words are driven through the
// input handshake with expected results pushed onto a scoreboard queue; a
// monitor pops and compares on every output handshake.
// ---------------------------------------------------------------------------
module tb_csd_to_bin_serial;

    localparam int N = 9;
    localparam int W = N + 1;

    typedef struct {
        logic [N-1:0] mag;
        logic [N-1:0] sign;
        logic [W-1:0] expData;
        logic         expErr;
    } vecT;

    typedef struct {
        logic [W-1:0] data;
        logic         err;
    } expT;

    logic clk;
    logic rst_n;
    int   compared;
    int   mismatched;
    expT  sbQ[$];

    csd_to_bin_serial_if #(.N(N), .W(W)) bus ();

    csd_to_bin_serial #(.N(N), .W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: direct positional sum of signed digits.
    function automatic logic [W-1:0] modelData(input logic [N-1:0] mag, input logic [N-1:0] sign);
        int v;
        v = 0;
        for (int k = 0; k < N; k++) begin
            if (mag[k]) v = sign[k] ? v - (1 << k) : v + (1 << k);
        end
        return W'(v);
    endfunction

    function automatic logic modelErr(input logic [N-1:0] mag);
        for (int k = 0; k < N - 1; k++) begin
            if (mag[k] && mag[k+1]) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, required, $time);
        end
    endtask

    // Drive one word, optionally register its expected result, and wait
    // (bounded) for the accepting edge. Returns one tick after that edge with
    // the input fields scrambled to show they are not resampled.
    task automatic applyStimulus(input logic [N-1:0] mag, input logic [N-1:0] sign,
                                 input logic [W-1:0] expData, input logic expErr, input bit doPush);
        int waited;
        expT e;
        if (doPush) begin
            e.data = expData;
            e.err  = expErr;
            sbQ.push_back(e);
        end
        bus.in_valid = 1'b1;
        bus.in_mag   = mag;
        bus.in_sign  = sign;
        waited = 0;
        while (!bus.in_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!bus.in_ready) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL acceptTimeout: in_ready=%0b, expected 1 within 100 cycles", bus.in_ready);
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_mag   = N'($urandom);
        bus.in_sign  = N'($urandom);
    endtask

    task automatic waitDrain();
        int waited;
        waited = 0;
        while (sbQ.size() != 0 && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (sbQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drainTimeout: %0d results pending, expected 0", sbQ.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic countLatency(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 30) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Scoreboard monitor: every output handshake pops one expected result.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sbQ.size() == 0) begin
                compared++;
                mismatched++;
                $display("[TB] FAIL unexpectedOutput: data=0x%0h, expected no output", bus.out_data);
            end else begin
                expT e;
                e = sbQ.pop_front();
                checkOutput("outData", 32'(bus.out_data), 32'(e.data));
                checkOutput("outErr", 32'(bus.out_err), 32'(e.err));
            end
        end
    end

    // Global watchdog.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecT vecs[8];
        int  lat;
        logic [N-1:0] rm, rs;
        logic [W-1:0] holdExp;

        vecs[0] = '{9'b100000001, 9'b000000001, 10'd255,  1'b0};
        vecs[1] = '{9'b000000001, 9'b000000000, 10'd1,    1'b0};
        vecs[2] = '{9'b101010101, 9'b111111111, 10'h2AB,  1'b0};
        vecs[3] = '{9'b101010101, 9'b000000000, 10'd341,  1'b0};
        vecs[4] = '{9'b000000011, 9'b000000000, 10'd3,    1'b1};
        vecs[5] = '{9'b000000010, 9'b000000011, 10'h3FE,  1'b0};
        vecs[6] = '{9'b000000000, 9'b111111111, 10'd0,    1'b0};
        vecs[7] = '{9'b110000000, 9'b010000000, 10'd128,  1'b1};

        compared     = 0;
        mismatched   = 0;
        bus.in_valid  = 1'b0;
        bus.in_mag    = '0;
        bus.in_sign   = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b1;

        // Reset values while rst_n is low.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstInReady", 32'(bus.in_ready), 32'd0);
        checkOutput("rstOutValid", 32'(bus.out_valid), 32'd0);
        checkOutput("rstOutData", 32'(bus.out_data), 32'd0);
        checkOutput("rstOutErr", 32'(bus.out_err), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checkOutput("idleInReady", 32'(bus.in_ready), 32'd1);

        // Zero word: first-transaction latency.
        bus.out_ready = 1'b1;
        applyStimulus('0, '0, '0, 1'b0, 1'b1);
        countLatency(lat);
        checkOutput("latencyZero", 32'(lat), 32'(N));

        // Table vectors, streamed back to back.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].mag, vecs[i].sign, vecs[i].expData, vecs[i].expErr, 1'b1);
        end

        // Random words checked against the positional model.
        for (int i = 0; i < 16; i++) begin
            rm = N'($urandom);
            rs = N'($urandom);
            applyStimulus(rm, rs, modelData(rm, rs), modelErr(rm), 1'b1);
        end
        waitDrain();

        // Backpressure in DONE with a new word already waiting.
        bus.out_ready = 1'b0;
        rm = 9'b010100101;
        rs = 9'b000100001;
        holdExp = modelData(rm, rs);
        applyStimulus(rm, rs, holdExp, modelErr(rm), 1'b1);
        countLatency(lat);
        checkOutput("bpLatency", 32'(lat), 32'(N));
        rm = 9'b100100100;
        rs = 9'b100000100;
        applyStimulus_hold: begin
            expT e;
            e.data = modelData(rm, rs);
            e.err  = modelErr(rm);
            sbQ.push_back(e);
            bus.in_valid = 1'b1;
            bus.in_mag   = rm;
            bus.in_sign  = rs;
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checkOutput("bpOutValid", 32'(bus.out_valid), 32'd1);
            checkOutput("bpInReady", 32'(bus.in_ready), 32'd0);
            checkOutput("bpOutData", 32'(bus.out_data), 32'(holdExp));
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_mag   = N'($urandom);
        bus.in_sign  = N'($urandom);
        checkOutput("bpOutValidDrop", 32'(bus.out_valid), 32'd0);
        countLatency(lat);
        checkOutput("bpNextLatency", 32'(lat), 32'(N));
        waitDrain();

        // Reset during RUN discards the partial word.
        applyStimulus(9'b111111111, 9'b000000000, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midRstOutValid", 32'(bus.out_valid), 32'd0);
        checkOutput("midRstInReady", 32'(bus.in_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        checkOutput("postRstInReady", 32'(bus.in_ready), 32'd1);
        checkOutput("postRstOutValid", 32'(bus.out_valid), 32'd0);
        applyStimulus(9'b100000000, 9'b000000000, 10'd256, 1'b0, 1'b1);
        countLatency(lat);
        checkOutput("postRstLatency", 32'(lat), 32'(N));
        waitDrain();

        checkOutput("sbEmpty", 32'(sbQ.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
